// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter and five-phase one-hot sequencer
// IDLE/P1..P5 control with stop, halt and branch load at the instruction boundary.
module pc_sequencer #(
  parameter int               WIDTH    = 16,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             halt_in,
  input  logic             pc_load,
  input  logic [WIDTH-1:0] branch_target,
  output logic [4:0]       phase,
  output logic [WIDTH-1:0] pc,
  output logic             running,
  output logic [15:0]      retired
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_P1,
    S_P2,
    S_P3,
    S_P4,
    S_P5
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [15:0]      retired_q, retired_d;
  logic             stop_pend_q, stop_pend_d;
  logic [4:0]       phase_q, phase_d;
  logic             running_q, running_d;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    retired_d   = retired_q;
    stop_pend_d = stop_pend_q;
    phase_d     = 5'b0;
    running_d   = 1'b0;

    unique case (state_q)
      S_IDLE: if (start && !stop) state_d = S_P1;
      S_P1: begin
        state_d = S_P2;
        pc_d    = pc_q + WIDTH'(1);
      end
      S_P2: state_d = S_P3;
      S_P3: state_d = S_P4;
      S_P4: state_d = S_P5;
      S_P5: begin
        retired_d = retired_q + 16'd1;
        if (pc_load) pc_d = branch_target;
        // A stop arriving in P5 itself is honoured at this same boundary.
        if (halt_in || stop_pend_q || stop) state_d = S_IDLE;
        else                                state_d = S_P1;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_q != S_IDLE && stop) stop_pend_d = 1'b1;
    if (state_d == S_IDLE)         stop_pend_d = 1'b0;

    // Outputs are registered from the next state so they line up with it.
    unique case (state_d)
      S_P1:    phase_d = 5'b00001;
      S_P2:    phase_d = 5'b00010;
      S_P3:    phase_d = 5'b00100;
      S_P4:    phase_d = 5'b01000;
      S_P5:    phase_d = 5'b10000;
      default: phase_d = 5'b00000;
    endcase
    running_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      retired_q   <= 16'd0;
      stop_pend_q <= 1'b0;
      phase_q     <= 5'b0;
      running_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      retired_q   <= retired_d;
      stop_pend_q <= stop_pend_d;
      phase_q     <= phase_d;
      running_q   <= running_d;
    end
  end

  assign phase   = phase_q;
  assign pc      = pc_q;
  assign running = running_q;
  assign retired = retired_q;

endmodule
